// File: rtl/byte_serial_adder.sv
// byte_serial_adder
//   Multi-cycle wide adder. Operands are accepted on an in_valid/in_ready
//   handshake, then added one byte per clock through an 8-bit
//   carry-lookahead slice with the carry registered between bytes. The
//   result is presented on an out_valid/out_ready handshake.
//
// Parameters
//   NBYTES     operand width in bytes (1..16), W = 8*NBYTES
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   a, b       W-bit operands, sampled on input handshake
//   cin        carry into byte 0
//   in_valid   operands valid
//   in_ready   block can accept operands (IDLE only)
//   sum        registered W-bit result
//   cout       carry out of the MSB
//   overflow   two's-complement signed overflow
//   out_valid  result valid
//   out_ready  consumer accepts result
//
// Build option
//   BYTE_SERIAL_ADDER_SATURATE_EN  when defined, a signed overflow replaces
//   sum with the saturated value (0x7F..FF or 0x80..00); cout stays raw.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | adding one byte per cycle, LSB first
// DONE  | result held, out_valid=1 until out_ready
module byte_serial_adder #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  overflow,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int W    = 8 * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_sh_q, a_sh_d;
    logic [W-1:0]    b_sh_q, b_sh_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            overflow_q, overflow_d;
    logic [IDXW-1:0] idx_q, idx_d;

    logic [7:0]      sl_sum;
    logic            sl_g, sl_p;
    logic            carry_next;
    logic [W+7:0]    sum_shift;
    logic            ovf_now;

    // 8-bit carry-lookahead slice on the low byte of the operand shift
    // registers. Group generate/propagate feed the inter-byte carry.
    always_comb begin
        logic [7:0] g;
        logic [7:0] p;
        logic       c;
        logic       gg;
        g  = a_sh_q[7:0] & b_sh_q[7:0];
        p  = a_sh_q[7:0] ^ b_sh_q[7:0];
        c  = carry_q;
        gg = 1'b0;
        sl_sum = '0;
        for (int i = 0; i < 8; i++) begin
            sl_sum[i] = p[i] ^ c;
            c         = g[i] | (p[i] & c);
            gg        = g[i] | (p[i] & gg);
        end
        sl_g       = gg;
        sl_p       = &p;
        carry_next = sl_g | (sl_p & carry_q);
        // New byte enters at the MSB end; works for NBYTES=1 too.
        sum_shift  = {sl_sum, sum_q} >> 8;
        // On the last byte the low slice byte holds the operand MSBs.
        ovf_now    = (a_sh_q[7] == b_sh_q[7]) && (sl_sum[7] != a_sh_q[7]);
    end

    always_comb begin
        state_d    = state_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        sum_d      = sum_q;
        carry_d    = carry_q;
        cout_d     = cout_q;
        overflow_d = overflow_q;
        idx_d      = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> 8;
                b_sh_d  = b_sh_q >> 8;
                sum_d   = sum_shift[W-1:0];
                carry_d = carry_next;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d     = carry_next;
                    overflow_d = ovf_now;
                    idx_d      = '0;
                    state_d    = DONE;
`ifdef BYTE_SERIAL_ADDER_SATURATE_EN
                    if (ovf_now) begin
                        sum_d = a_sh_q[7] ? {1'b1, {(W-1){1'b0}}}
                                          : {1'b0, {(W-1){1'b1}}};
                    end
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            sum_q      <= '0;
            carry_q    <= 1'b0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            sum_q      <= sum_d;
            carry_q    <= carry_d;
            cout_q     <= cout_d;
            overflow_q <= overflow_d;
            idx_q      <= idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !reset;
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_byte_serial_adder.sv
module tb_byte_serial_adder;

    localparam int N = 4;
    localparam int W = 8 * N;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] a, b;
    logic         cin, in_valid, in_ready, cout, overflow, out_valid, out_ready;
    logic [W-1:0] sum;

    logic [7:0]   a1, b1, sum1;
    logic         cin1, in_valid1, in_ready1, cout1, overflow1, out_valid1, out_ready1;

    always #5 clk = ~clk;

    byte_serial_adder #(.NBYTES(N)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .cin(cin),
        .in_valid(in_valid), .in_ready(in_ready),
        .sum(sum), .cout(cout), .overflow(overflow),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    byte_serial_adder #(.NBYTES(1)) dut1 (
        .clk(clk), .reset(reset), .a(a1), .b(b1), .cin(cin1),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .sum(sum1), .cout(cout1), .overflow(overflow1),
        .out_valid(out_valid1), .out_ready(out_ready1)
    );

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    exp_t q[$];
    exp_t q1[$];
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input int nb);
        exp_t         e;
        logic [W:0]   full;
        int           msb;
        msb  = 8 * nb - 1;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        e.s  = full[W-1:0];
        e.c  = full[8*nb];
        e.v  = (x[msb] == y[msb]) && (full[msb] != x[msb]);
        if (nb < N) e.s = e.s & ((W'(1) << (8 * nb)) - W'(1));
`ifdef BYTE_SERIAL_ADDER_SATURATE_EN
        if (e.v) begin
            e.s = '0;
            if (x[msb]) e.s[msb] = 1'b1;
            else e.s = (W'(1) << msb) - W'(1);
        end
`endif
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input bit push);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        check("in_ready_wait", 64'(in_ready), 64'd1);
        a = x; b = y; cin = ci; in_valid = 1'b1;
        if (push) q.push_back(model(x, y, ci, N));
        tick();
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
    endtask

    task automatic collect();
        int   lat;
        exp_t e;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("latency", 64'(lat), 64'(N));
        if (q.size() == 0) begin
            check("scoreboard_empty", 64'(q.size()), 64'd1);
        end else begin
            e = q.pop_front();
            check("sum", 64'(sum), 64'(e.s));
            check("cout", 64'(cout), 64'(e.c));
            check("overflow", 64'(overflow), 64'(e.v));
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_after_hs", 64'(out_valid), 64'd0);
        check("in_ready_after_hs", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [W-1:0] s_hold;
        logic         c_hold, v_hold;
        exp_t         e1;
        int           n;

        reset = 1'b1; a = '0; b = '0; cin = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a1 = '0; b1 = '0; cin1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        reset = 1'b0;
        tick();
        check("idle_in_ready", 64'(in_ready), 64'd1);

        // Directed cases from the plan, plus signed edge cases
        accept(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b1); collect(); release_out();
        accept(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1); collect(); release_out();
        accept(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1); collect(); release_out();
        accept(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1); collect(); release_out();
        for (int i = 0; i < 6; i++) begin
            accept($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
            collect();
            release_out();
        end

        // Backpressure: result held, new operands ignored until handshake
        accept(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b1);
        collect();
        s_hold = sum; c_hold = cout; v_hold = overflow;
        in_valid = 1'b1; a = 32'h0000_0003; b = 32'h0000_0004; cin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_sum", 64'(sum), 64'(s_hold));
            check("hold_cout", 64'(cout), 64'(c_hold));
            check("hold_overflow", 64'(overflow), 64'(v_hold));
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_out_valid", 64'(out_valid), 64'd1);
        end
        release_out();
        accept(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b1);
        collect();
        release_out();

        // Reset during the second RUN cycle must discard everything
        accept(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_sum", 64'(sum), 64'd0);
        check("abort_cout", 64'(cout), 64'd0);
        accept(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1);
        collect();
        release_out();

        // Single-byte instance
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (!in_ready1 && n < 20) begin
                tick();
                n++;
            end
            check("n1_in_ready", 64'(in_ready1), 64'd1);
            a1 = (k == 0) ? 8'h80 : 8'h7F;
            b1 = (k == 0) ? 8'h80 : 8'h01;
            cin1 = 1'b0;
            in_valid1 = 1'b1;
            q1.push_back(model(W'(a1), W'(b1), cin1, 1));
            tick();
            in_valid1 = 1'b0;
            check("n1_out_valid_early", 64'(out_valid1), 64'd0);
            tick();
            check("n1_out_valid", 64'(out_valid1), 64'd1);
            e1 = q1.pop_front();
            check("n1_sum", 64'(sum1), 64'(e1.s[7:0]));
            check("n1_cout", 64'(cout1), 64'(e1.c));
            check("n1_overflow", 64'(overflow1), 64'(e1.v));
            out_ready1 = 1'b1;
            tick();
            out_ready1 = 1'b0;
            check("n1_out_valid_after_hs", 64'(out_valid1), 64'd0);
        end

        check("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/byte_serial_adder.md
Name: byte_serial_adder

Overview:
- Multi-cycle wide adder that feeds the team's 8-bit carry-lookahead slice (fcla8) one byte per cycle.
- Registers the carry between slices; it is the sequential wrapper around the combinational CLA slice.
- Used where wide (up to 128-bit) sums are needed in the FPGA datapath without a full-width carry chain.
- Valid/ready handshake on input and output.

Parameters:
NBYTES, 4, operand width in bytes; legal range 1..16; total width W = 8*NBYTES.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
a  input  W  operand A, sampled on input handshake
b  input  W  operand B, sampled on input handshake
cin  input  1  carry-in to byte 0
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
sum  output  W  result, registered
cout  output  1  carry out of MSB
overflow  output  1  two's-complement signed overflow
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset: state=IDLE, sum=0, cout=0, overflow=0, out_valid=0, carry reg=0, byte index=0. in_ready=0 while reset is high.
- in_ready=1 only in IDLE. It is derived from the state register.
- IDLE: on in_valid & in_ready, latch a, b, cin into operand shift registers and the carry reg, set idx=0, and go to RUN.
- RUN, one byte per cycle:
  - fcla8 slice inputs: A=a_sh[7:0], B=b_sh[7:0], Cin=carry.
  - Slice sum byte is shifted into the MSB end of the result shift register.
  - carry <= G | (P & carry).
  - Operand shift registers shift right by 8.
  - idx increments.
- RUN exit: when idx==NBYTES-1, that cycle's update also sets cout=final carry and overflow=(a_msb==b_msb)&(sum_msb!=a_msb), and the next state is DONE.
- Latency: out_valid rises exactly NBYTES cycles after the acceptance edge.
- DONE: out_valid=1. sum, cout and overflow are held stable until out_valid & out_ready. On that handshake: out_valid=0 and return to IDLE. Outputs keep their last values (no clearing).
- Throughput: one operation per NBYTES+2 cycles minimum. No overlap: in_valid is ignored in RUN and DONE.
- NBYTES=1: RUN lasts a single cycle; behaviour is otherwise identical.
- Reset mid-operation (RUN or DONE): abort immediately, all registers return to reset values, and the partial result is discarded. No stale carry may reach the next operation.
- in_valid and out_ready both high in DONE: only the output handshake completes; the new input is accepted at the earliest in the following IDLE cycle.
- a and b need not be stable after acceptance.

Optional Feature:
- Macro: BYTE_SERIAL_ADDER_SATURATE_EN.
- Defined: on signed overflow, sum is replaced at DONE entry by the saturated value. Positive overflow (a_msb=0) gives 0x7F..FF; negative overflow gives 0x80..00. overflow is still reported as 1; cout is unchanged (raw carry).
- Undefined: sum is the raw wrap-around result. No extra logic is generated.

Test Plan:
- NBYTES=4, a=0x000000FF, b=0x00000001, cin=0 -> sum=0x00000100, cout=0, overflow=0; out_valid high 4 cycles after accept.
- a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1, overflow=0 (carry ripples through all 4 slice cycles).
- a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, overflow=1, cout=0; with SATURATE_EN, sum=0x7FFFFFFF, overflow=1.
- Complete an add, then hold out_ready=0 for 3 cycles while in_valid=1 with new operands -> sum/cout/overflow stable, in_ready=0, new operands not consumed; raise out_ready -> IDLE next cycle, then new operands accepted.
- Assert reset during the 2nd RUN cycle of a=0xFFFFFFFF + b=1 -> next cycle out_valid=0, sum=0. Then 0x00000001+0x00000001, cin=0 -> sum=0x00000002 (no stale carry).
- NBYTES=1, a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, overflow=1, out_valid 1 cycle after accept; with SATURATE_EN, sum=0x80.
